// File: rtl/lp_pkg.sv
// Shared definitions for the LEGv8-subset multi-cycle control path.
// Opcode constants, instruction classes and sequencer states.
package lp_pkg;

  localparam int OP_W = 11;

  localparam logic [OP_W-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OP_W-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OP_W-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OP_W-1:0] OP_ORR  = 11'b10101010000;
  localparam logic [OP_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OP_W-1:0] OP_STUR = 11'b11111000000;
  localparam logic [OP_W-1:0] OP_HALT = 11'b00000000000;

  localparam logic [7:0] CBZ_PFX = 8'b10110100;
  localparam logic [5:0] B_PFX   = 6'b000101;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_LOAD,
    CL_STORE,
    CL_CBRANCH,
    CL_BRANCH,
    CL_HALT,
    CL_ILLEGAL
  } iclass_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier, shared with ALU control.
// Exact matches for most classes; CBZ and B match on a prefix.
module opcode_decoder
  import lp_pkg::*;
#(
  parameter int OPCODE_W = 11
) (
  input  logic [OPCODE_W-1:0] opcode,
  output iclass_t             cls
);

  logic is_rtype;
  logic is_cbz;
  logic is_b;

  assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_ORR);
  assign is_cbz   = (opcode[OPCODE_W-1 -: 8] == CBZ_PFX);
  assign is_b     = (opcode[OPCODE_W-1 -: 6] == B_PFX);

  always_comb begin
    cls = CL_ILLEGAL;
    unique case (1'b1)
      is_rtype:            cls = CL_RTYPE;
      (opcode == OP_LDUR): cls = CL_LOAD;
      (opcode == OP_STUR): cls = CL_STORE;
      is_cbz:              cls = CL_CBRANCH;
      is_b:                cls = CL_BRANCH;
      (opcode == OP_HALT): cls = CL_HALT;
      default:             cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with
// memory handshakes, PC update control and a retired-instruction counter.
module pc_sequencer
  import lp_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int RETIRE_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zeroFlag,
  input  logic                imemAck,
  input  logic                dmemAck,
  output logic                imemReq,
  output logic                irWrite,
  output logic                dmemRead,
  output logic                dmemWrite,
  output logic                regWrite,
  output logic                pcWrite,
  output logic                branchTaken,
  output logic [RETIRE_W-1:0] retireCount,
  output logic                halted,
  output logic                illegal
);

  state_t  state;
  state_t  state_nx;
  iclass_t cls_d;
  iclass_t cls_q;
  logic    illegal_q;

  opcode_decoder #(
    .OPCODE_W(OPCODE_W)
  ) u_dec (
    .opcode(opcode),
    .cls   (cls_d)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_FETCH;
      cls_q       <= CL_ILLEGAL;
      illegal_q   <= 1'b0;
      retireCount <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_DECODE) begin
        cls_q <= cls_d;
        if (cls_d == CL_ILLEGAL) illegal_q <= 1'b1;
      end
      if (pcWrite) retireCount <= retireCount + RETIRE_W'(1);
    end
  end

  always_comb begin
    state_nx    = state;
    imemReq     = 1'b0;
    irWrite     = 1'b0;
    dmemRead    = 1'b0;
    dmemWrite   = 1'b0;
    regWrite    = 1'b0;
    pcWrite     = 1'b0;
    branchTaken = 1'b0;
    unique case (state)
      ST_FETCH: begin
        // held in FETCH during reset, so keep strobes quiet there
        if (reset_n) begin
          imemReq = 1'b1;
          if (imemAck) begin
            irWrite  = 1'b1;
            state_nx = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        if (cls_d == CL_HALT || cls_d == CL_ILLEGAL)
          state_nx = ST_HALTED;
        else
          state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        unique case (cls_q)
          CL_CBRANCH: begin
            pcWrite     = 1'b1;
            branchTaken = zeroFlag;
            state_nx    = ST_FETCH;
          end
          CL_BRANCH: begin
            pcWrite     = 1'b1;
            branchTaken = 1'b1;
            state_nx    = ST_FETCH;
          end
          CL_RTYPE: state_nx = ST_WB;
          CL_LOAD:  state_nx = ST_MEM;
          CL_STORE: state_nx = ST_MEM;
          default:  state_nx = ST_HALTED;
        endcase
      end
      ST_MEM: begin
        dmemRead  = (cls_q == CL_LOAD);
        dmemWrite = (cls_q == CL_STORE);
        if (dmemAck) begin
          if (cls_q == CL_STORE) begin
            pcWrite  = 1'b1;
            state_nx = ST_FETCH;
          end else begin
            state_nx = ST_WB;
          end
        end
      end
      ST_WB: begin
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_HALTED: state_nx = ST_HALTED;
      default:   state_nx = ST_HALTED;
    endcase
  end

  assign halted  = (state == ST_HALTED);
  assign illegal = illegal_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle control sequencer for the LEGv8-subset core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the instruction and data memory request handshakes, the register-file write strobe and the PC update, including the enable and the branch/next-instruction select into the PC unit. It also counts retired instructions and halts on a HALT or illegal opcode.

## Interface
Parameters:
- OPCODE_W, 11, width of the opcode field (instruction[31:21])
- RETIRE_W, 32, width of the retired-instruction counter

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  OPCODE_W  instruction[31:21], valid from the cycle after irWrite
- zeroFlag  in  1  ALU zero result, sampled in EXEC
- imemAck  in  1  instruction memory has data this cycle
- dmemAck  in  1  data memory access completes this cycle
- imemReq  out  1  instruction fetch request
- irWrite  out  1  instruction register load strobe
- dmemRead  out  1  data memory read request (LDUR)
- dmemWrite  out  1  data memory write request (STUR)
- regWrite  out  1  register file write strobe
- pcWrite  out  1  PC update enable, one pulse per retired instruction
- branchTaken  out  1  PC mux select: 0 = PC+4, 1 = PC + (offset<<2)
- retireCount  out  RETIRE_W  retired instruction count
- halted  out  1  sequencer stopped (sticky)
- illegal  out  1  halt was caused by an unrecognised opcode (sticky)

## Operation
- Opcode classes (exact match unless noted):
  - R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - LDUR 11111000010
  - STUR 11111000000
  - CBZ: top 8 bits 10110100
  - B: top 6 bits 000101
  - HALT 00000000000
  - anything else is illegal
- FETCH: imemReq=1 until imemAck. irWrite=1 in the ack cycle only. Go to DECODE on the ack.
- DECODE: one cycle, classify the opcode, register the class.
  - HALT → HALTED (illegal=0)
  - illegal class → HALTED (illegal=1)
  - otherwise → EXEC
- EXEC: one cycle.
  - CBZ: pcWrite=1, branchTaken=zeroFlag; retire; go to FETCH.
  - B: pcWrite=1, branchTaken=1; retire; go to FETCH.
  - R-type: go to WB.
  - LDUR/STUR: go to MEM.
- MEM: dmemRead (LDUR) or dmemWrite (STUR) held high until dmemAck.
  - STUR on ack: pcWrite=1, branchTaken=0; retire; go to FETCH.
  - LDUR on ack: go to WB.
- WB: regWrite=1, pcWrite=1, branchTaken=0; retire; go to FETCH.
- HALTED: absorbing state. All strobes stay 0 and retireCount is frozen until reset_n is asserted.
- Retire: retireCount increments on the same edge at which pcWrite is high. It wraps from all-ones to 0 silently.
- HALT and illegal instructions do not retire and never assert pcWrite.
- branchTaken is 0 whenever pcWrite is 0.

## Timing
- Reset (asynchronous, reset_n=0):
  - state=FETCH, retireCount=0, halted=0, illegal=0
  - every strobe 0; imemReq rises combinationally from FETCH once reset_n deasserts
- All outputs are Moore/registered-state decodes, except that irWrite, pcWrite and the retire increment are gated by imemAck/dmemAck in the same cycle.
- Minimum cycles per instruction, with acks in the first request cycle:
  - B/CBZ: 3
  - R-type: 4
  - STUR: 4
  - LDUR: 5
- Each additional cycle of ack latency adds one cycle.
- An ack while no request is pending is ignored. dmemAck during FETCH and imemAck during MEM are both ignored.
- Requests never drop before their ack. There is no timeout.
- reset_n asserted mid-MEM: requests drop immediately and the in-flight instruction is not retired.
- zeroFlag is only sampled in EXEC; its value in other states has no effect.

## Structure
- Shared package `lp_pkg` holds:
  - the opcode constants and CBZ/B prefix masks
  - the instruction-class enum (RTYPE, LOAD, STORE, CBRANCH, BRANCH, HALT, ILLEGAL)
  - the state enum (FETCH, DECODE, EXEC, MEM, WB, HALTED)
- One sub-module, `opcode_decoder`: combinational opcode → class, so it can be reused by the ALU control.
- The FSM and the retire counter live in pc_sequencer.

## Test plan
- Reset, then release with imemAck tied 1 and opcode ADD: irWrite in cycle 1, regWrite and pcWrite in cycle 4 with branchTaken=0, retireCount=1.
- CBZ with zeroFlag=1 in EXEC, then CBZ with zeroFlag=0: pcWrite in cycle 3 both times; branchTaken 1 then 0; retireCount=2.
- LDUR with dmemAck delayed 3 cycles: dmemRead held for 4 cycles, then regWrite and pcWrite one cycle after the ack; 8 cycles total.
- STUR with imemAck delayed 2 cycles: pcWrite on the dmemAck cycle with no regWrite; retireCount=1.
- Opcode 11111111111: halted=1 and illegal=1 after DECODE; no pcWrite for 20 following cycles. Opcode 00000000000: halted=1, illegal=0.
- reset_n pulsed low during MEM of LDUR: dmemRead falls asynchronously and retireCount=0. Force retireCount to all-ones, retire one B: count wraps to 0.
